// File: rtl/varredura_matriz_leds_if.sv
// Bundle between the per-column map multiplexer and the LED matrix scan driver.
//
// Signals:
//   enable            1 = matrix active (preparation/attack with life remaining)
//   mapa0..mapa4      column images, bit i = row i lit
//   piscar0..piscar4  blink mask, bit set = cell blinks
//   l                 row drive, active-high
//   c                 column drive, active-low, at most one bit low
//   frame_start       one-cycle pulse when the column 0 slot begins
//
// Modports:
//   master  source of the images and enable (the map multiplexer side)
//   slave   the scan driver
interface varredura_matriz_leds_if;
  logic       enable;
  logic [6:0] mapa0;
  logic [6:0] mapa1;
  logic [6:0] mapa2;
  logic [6:0] mapa3;
  logic [6:0] mapa4;
  logic [6:0] piscar0;
  logic [6:0] piscar1;
  logic [6:0] piscar2;
  logic [6:0] piscar3;
  logic [6:0] piscar4;
  logic [6:0] l;
  logic [4:0] c;
  logic       frame_start;

  modport master (
    output enable,
    output mapa0, mapa1, mapa2, mapa3, mapa4,
    output piscar0, piscar1, piscar2, piscar3, piscar4,
    input  l, c, frame_start
  );

  modport slave (
    input  enable,
    input  mapa0, mapa1, mapa2, mapa3, mapa4,
    input  piscar0, piscar1, piscar2, piscar3, piscar4,
    output l, c, frame_start
  );
endinterface

// File: rtl/varredura_matriz_leds.sv
// Scan driver for the 7x5 LED matrix.
//
// Drives one column at a time with its row pattern. Each column owns a slot of TICK_DIV
// clock cycles; the first DEAD_CYCLES of every slot keep all columns off to suppress
// ghosting. Column images and blink masks are copied into shadow buffers only at frame
// boundaries, so an image never tears mid-frame. Masked cells go dark on alternate
// blink half-periods of BLINK_FRAMES frames.
//
// Ports:
//   clock_in  board clock
//   reset     asynchronous, active-high reset
//   bus       slave side of varredura_matriz_leds_if (enable, mapaN, piscarN in;
//             l, c, frame_start out)
//
// Parameters:
//   TICK_DIV      clock cycles per column slot (>= 2)
//   DEAD_CYCLES   all-off cycles at the start of each slot (< TICK_DIV)
//   BLINK_FRAMES  complete frames per blink half-period (>= 1)
//
// Output timing: l and c are registered from the scan state, so they trail the internal
// prescaler/column by one cycle. frame_start is high during the cycle in which the
// internal state is column 0, prescaler 0.
module varredura_matriz_leds #(
  parameter int unsigned TICK_DIV     = 50000,
  parameter int unsigned DEAD_CYCLES  = 500,
  parameter int unsigned BLINK_FRAMES = 25
) (
  input logic                    clock_in,
  input logic                    reset,
  varredura_matriz_leds_if.slave bus
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0] SlotLast  = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] DeadEnd   = PW'(DEAD_CYCLES);
  localparam logic [BW-1:0] BlinkLast = BW'(BLINK_FRAMES - 1);
  localparam logic [2:0]    ColLast   = 3'd4;
  localparam logic [4:0]    ColsOff   = 5'b11111;

  // StIdle: disabled or just out of reset; the next enabled edge starts a frame.
  typedef enum logic [0:0] {StIdle, StScan} state_e;

  state_e          state_q;
  logic [PW-1:0]   presc_q;
  logic [2:0]      col_q;
  logic [BW-1:0]   blink_cnt_q;
  logic            blink_phase_q;
  logic [4:0][6:0] sh_mapa_q;
  logic [4:0][6:0] sh_piscar_q;
  logic [6:0]      l_q;
  logic [4:0]      c_q;
  logic            frame_start_q;

  logic            slot_end;
  logic            frame_edge;
  logic            in_dead;
  logic [6:0]      row_map;
  logic [6:0]      row_blink;
  logic [4:0]      col_mask;
  logic [4:0]      drive_c;
  logic [6:0]      drive_l;

  // Scan decode and row selection from the current internal state.
  always_comb begin
    slot_end   = (presc_q == SlotLast);
    // Entering from idle (reset release or enable rise) is also a frame boundary.
    frame_edge = (state_q == StIdle) || (slot_end && (col_q == ColLast));
    in_dead    = (presc_q < DeadEnd);

    row_map   = '0;
    row_blink = '0;
    col_mask  = ColsOff;
    case (col_q)
      3'd0: begin
        row_map   = sh_mapa_q[0];
        row_blink = sh_piscar_q[0];
        col_mask  = 5'b11110;
      end
      3'd1: begin
        row_map   = sh_mapa_q[1];
        row_blink = sh_piscar_q[1];
        col_mask  = 5'b11101;
      end
      3'd2: begin
        row_map   = sh_mapa_q[2];
        row_blink = sh_piscar_q[2];
        col_mask  = 5'b11011;
      end
      3'd3: begin
        row_map   = sh_mapa_q[3];
        row_blink = sh_piscar_q[3];
        col_mask  = 5'b10111;
      end
      3'd4: begin
        row_map   = sh_mapa_q[4];
        row_blink = sh_piscar_q[4];
        col_mask  = 5'b01111;
      end
      default: begin
        row_map   = '0;
        row_blink = '0;
        col_mask  = ColsOff;
      end
    endcase

    if ((state_q == StScan) && !in_dead) begin
      drive_c = col_mask;
      drive_l = row_map & ~(row_blink & {7{blink_phase_q}});
    end else begin
      drive_c = ColsOff;
      drive_l = '0;
    end
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      presc_q       <= '0;
      col_q         <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      sh_mapa_q     <= '0;
      sh_piscar_q   <= '0;
      l_q           <= '0;
      c_q           <= ColsOff;
      frame_start_q <= 1'b0;
    end else if (!bus.enable) begin
      // Blink state and shadow buffers are deliberately kept across a disable.
      state_q       <= StIdle;
      presc_q       <= '0;
      col_q         <= '0;
      l_q           <= '0;
      c_q           <= ColsOff;
      frame_start_q <= 1'b0;
    end else begin
      l_q           <= drive_l;
      c_q           <= drive_c;
      frame_start_q <= frame_edge;

      if (frame_edge) begin
        state_q     <= StScan;
        presc_q     <= '0;
        col_q       <= '0;
        sh_mapa_q   <= {bus.mapa4, bus.mapa3, bus.mapa2, bus.mapa1, bus.mapa0};
        sh_piscar_q <= {bus.piscar4, bus.piscar3, bus.piscar2, bus.piscar1, bus.piscar0};
        // Only wrap boundaries count frames; the start-up boundary does not.
        if (state_q == StScan) begin
          if (blink_cnt_q == BlinkLast) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= ~blink_phase_q;
          end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
          end
        end
      end else if (slot_end) begin
        presc_q <= '0;
        col_q   <= col_q + 3'd1;
      end else begin
        presc_q <= presc_q + 1'b1;
      end
    end
  end

  assign bus.l           = l_q;
  assign bus.c           = c_q;
  assign bus.frame_start = frame_start_q;

endmodule
